me_search_ctrl: RTL
===================

# me_search_ctrl

Full-search motion-estimation scheduler for the inter-prediction path. It walks the candidate motion vectors of a ±SR search window in raster order, one per cycle, and drives them to the PE array / SAD tree. It receives the 41 variable-block-size SADs (16 4x4, 8 4x8, 8 8x4, 4 8x8, 2 16x8, 2 8x16, 1 16x16) a fixed LAT cycles later and keeps, per partition, the minimum SAD and the motion vector that produced it. It sits between the macroblock-level encoder control and the SAD datapath.

## Interface
- PIX_WIDTH, 8: SAD word width; must match the SAD tree width.
- SR, 8: search range; candidates are x,y in [-SR, +SR].
- LAT, 9: cycles from a candidate being issued (pos_valid high) to its 41 SADs being valid on sad_in.
- MVW, $clog2(SR+1)+1: signed MV component width.
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin a search; sampled only in IDLE.
- abort  in  1  abandon the current search; no done pulse.
- pos_x, pos_y  out  MVW each, signed  candidate MV currently issued.
- pos_valid  out  1  pos_x/pos_y valid this cycle.
- sad_in  in  [0:40] x PIX_WIDTH  SADs, index order 4x4[0..15], 4x8[16..23], 8x4[24..31], 8x8[32..35], 16x8[36..37], 8x16[38..39], 16x16[40].
- busy  out  1  high in SCAN and DRAIN.
- done  out  1  one-cycle pulse: results final.
- best_sad  out  [0:40] x PIX_WIDTH  minimum SAD per partition.
- best_mvx, best_mvy  out  [0:40] x MVW each, signed  MV of that minimum.

## Operation
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE: start=1 -> SCAN. Load pos_x=pos_y=-SR and set the first-capture flag.
- SCAN: pos_valid=1 every cycle. x increments from -SR to +SR. At x=+SR, x wraps to -SR and y increments. After issuing (+SR,+SR) -> DRAIN. N=(2SR+1)^2 candidates.
- Pipeline: a LAT-deep delay line carries {pos_valid, pos_x, pos_y}. Its output is cap_v, cap_x, cap_y.
- Capture on cap_v. The first capture of a search loads all 41 entries unconditionally. After that, each entry k updates independently when sad_in[k] < best_sad[k] (unsigned, strict). Ties keep the earlier candidate in raster order.
- DRAIN: counts LAT cycles, then -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- best_* hold their values from done until the next search's first capture.
- start while busy or in DONE: ignored.
- abort=1 in SCAN or DRAIN: -> IDLE next cycle. The delay line is flushed (all valid bits 0). best_* are undefined-but-stable, and no done is generated. abort in IDLE or DONE: ignored.
- abort and start asserted together in IDLE: abort wins; stay IDLE.
- rst has priority over everything.

## Timing
- Reset values: state IDLE; pos_valid=0; pos_x=pos_y=0; busy=0; done=0; best_sad all ones; best_mvx=best_mvy=0; delay line valid bits 0.
- start sampled at edge 0 -> pos_valid high cycles 1..N, busy high cycles 1..N+LAT.
- Candidate issued in cycle t is captured at the edge ending cycle t+LAT. The last capture is in cycle N+LAT.
- done high in cycle N+LAT+1, with best_* final in that same cycle.
- Earliest accepted next start: sampled in cycle N+LAT+2 (IDLE).
- Total search time: N+LAT+1 cycles (SR=8, LAT=9: 299).
- rst asserted mid-search: all outputs take reset values at the next edge.

## Test plan
- SR=1, LAT=3, all SADs constant 50. Pulse start -> pos sequence (-1,-1),(0,-1),(1,-1),(-1,0)...(1,1) in cycles 1..9; done in cycle 13; every best_sad=50 and every best_mv=(-1,-1) (first capture plus tie rule).
- SR=1, LAT=3, sad_in[k]=100 except 10 at candidate (1,0) for k=40, and 5 at (0,1) for k=0 -> best_sad[40]=10, mv (1,0); best_sad[0]=5, mv (0,1); other entries 100, mv (-1,-1).
- All-ones SAD (255) at every candidate -> best_sad=255, best_mv=(-SR,-SR), confirming the first-capture load.
- abort in cycle 5 of an SR=1 search -> IDLE in cycle 6; no done; a new start in cycle 7 runs a complete search and gives correct results with no stale captures.
- rst in cycle 4 mid-scan -> all outputs at reset values next cycle; start re-sampled during busy is ignored (pos sequence uninterrupted, single done).
- SR=8, LAT=9 full run with random SADs -> each best_sad/mv matches a reference model; done in cycle 299.

Source files
------------

// File: rtl/me_search_ctrl_if.sv
// Bus between the macroblock-level encoder control / SAD datapath (master)
// and the full-search motion-estimation scheduler (slave).
interface me_search_ctrl_if #(
    parameter int PIX_WIDTH = 8,
    parameter int MVW       = 5
);
    logic                        start;
    logic                        abort;
    logic signed [MVW-1:0]       pos_x;
    logic signed [MVW-1:0]       pos_y;
    logic                        pos_valid;
    logic        [PIX_WIDTH-1:0] sad_in   [0:40];
    logic                        busy;
    logic                        done;
    logic        [PIX_WIDTH-1:0] best_sad [0:40];
    logic signed [MVW-1:0]       best_mvx [0:40];
    logic signed [MVW-1:0]       best_mvy [0:40];

    modport master (
        output start, abort, sad_in,
        input  pos_x, pos_y, pos_valid, busy, done, best_sad, best_mvx, best_mvy
    );

    modport slave (
        input  start, abort, sad_in,
        output pos_x, pos_y, pos_valid, busy, done, best_sad, best_mvx, best_mvy
    );
endinterface

// File: rtl/me_search_ctrl.sv
// Full-search ME scheduler: issues candidate MVs in raster order and keeps the
// per-partition minimum SAD and its MV for all 41 variable-size partitions.
module me_search_ctrl #(
    parameter int PIX_WIDTH = 8,
    parameter int SR        = 8,
    parameter int LAT       = 9,
    parameter int MVW       = $clog2(SR + 1) + 1
) (
    input  logic               clk,
    input  logic               rst,
    me_search_ctrl_if.slave    bus
);
    localparam int NPART = 41;
    localparam int CW    = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic signed [MVW-1:0] MV_MAX = MVW'(SR);
    localparam logic signed [MVW-1:0] MV_MIN = -MV_MAX;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic signed [MVW-1:0] pos_x_q, pos_y_q;
    logic [CW-1:0]         drain_cnt_q;
    logic                  first_q;

    logic                  dl_v_q [0:LAT-1];
    logic signed [MVW-1:0] dl_x_q [0:LAT-1];
    logic signed [MVW-1:0] dl_y_q [0:LAT-1];

    logic [PIX_WIDTH-1:0]  best_sad_q [0:NPART-1];
    logic signed [MVW-1:0] best_mvx_q [0:NPART-1];
    logic signed [MVW-1:0] best_mvy_q [0:NPART-1];
    logic [NPART-1:0]      upd;

    logic scan_active, last_pos, drain_end, abort_act, start_go, cap_v;

    assign scan_active = (state_q == SCAN);
    assign last_pos    = (pos_x_q == MV_MAX) && (pos_y_q == MV_MAX);
    assign drain_end   = (drain_cnt_q == CW'(LAT - 1));
    assign abort_act   = bus.abort && ((state_q == SCAN) || (state_q == DRAIN));
    assign start_go    = (state_q == IDLE) && (state_d == SCAN);
    assign cap_v       = dl_v_q[LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.start && !bus.abort) state_d = SCAN;
            SCAN:  if (bus.abort) state_d = IDLE;
                   else if (last_pos) state_d = DRAIN;
            DRAIN: if (bus.abort) state_d = IDLE;
                   else if (drain_end) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The position holds on the last candidate so pos_x/pos_y never wrap past +SR.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_x_q <= '0;
            pos_y_q <= '0;
        end else if (start_go) begin
            pos_x_q <= MV_MIN;
            pos_y_q <= MV_MIN;
        end else if (scan_active && !last_pos) begin
            if (pos_x_q == MV_MAX) begin
                pos_x_q <= MV_MIN;
                pos_y_q <= pos_y_q + MVW'(1);
            end else begin
                pos_x_q <= pos_x_q + MVW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state_q != DRAIN) begin
            drain_cnt_q <= '0;
        end else begin
            drain_cnt_q <= drain_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            first_q <= 1'b0;
        end else if (start_go) begin
            first_q <= 1'b1;
        end else if (cap_v) begin
            first_q <= 1'b0;
        end
    end

    // Candidate delay line aligned with the SAD tree latency; abort flushes it.
    always_ff @(posedge clk) begin
        if (rst || abort_act) begin
            for (int i = 0; i < LAT; i++) dl_v_q[i] <= 1'b0;
        end else begin
            dl_v_q[0] <= scan_active;
            for (int i = 1; i < LAT; i++) dl_v_q[i] <= dl_v_q[i-1];
        end
        dl_x_q[0] <= pos_x_q;
        dl_y_q[0] <= pos_y_q;
        for (int i = 1; i < LAT; i++) begin
            dl_x_q[i] <= dl_x_q[i-1];
            dl_y_q[i] <= dl_y_q[i-1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NPART; gi++) begin : g_upd
            assign upd[gi] = cap_v && (first_q || (bus.sad_in[gi] < best_sad_q[gi]));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NPART; k++) begin
                best_sad_q[k] <= '1;
                best_mvx_q[k] <= '0;
                best_mvy_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NPART; k++) begin
                if (upd[k]) begin
                    best_sad_q[k] <= bus.sad_in[k];
                    best_mvx_q[k] <= dl_x_q[LAT-1];
                    best_mvy_q[k] <= dl_y_q[LAT-1];
                end
            end
        end
    end

    assign bus.pos_x     = pos_x_q;
    assign bus.pos_y     = pos_y_q;
    assign bus.pos_valid = scan_active;
    assign bus.busy      = (state_q == SCAN) || (state_q == DRAIN);
    assign bus.done      = (state_q == DONE);
    assign bus.best_sad  = best_sad_q;
    assign bus.best_mvx  = best_mvx_q;
    assign bus.best_mvy  = best_mvy_q;
endmodule
